// File: rtl/ss_pkg.sv
// Shared types for the seven-segment scan path.
package ss_pkg;
  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_BLANK = '0;
  typedef enum logic {SHOW, BLANK} scan_state_e;
endpackage

// File: rtl/ss_frame_buf.sv
// Pending/display double buffer behind a valid/ready slave port.
module ss_frame_buf #(
  parameter int N_DIGITS = 2,
  parameter int SEG_W    = 7
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N_DIGITS-1:0][SEG_W-1:0]   s_data,
  input  logic                             commit,
  output logic [N_DIGITS-1:0][SEG_W-1:0]   disp
);
  logic [N_DIGITS-1:0][SEG_W-1:0] pend;
  logic pend_full, pend_full_nxt, xfer;

  // A transfer on the commit edge only happens with pend empty, so it lands
  // in pend and waits for the next boundary.
  always_comb begin
    xfer          = s_valid && s_ready;
    pend_full_nxt = pend_full;
    if (commit) pend_full_nxt = 1'b0;
    if (xfer)   pend_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend      <= '0;
      disp      <= '0;
      pend_full <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      pend_full <= pend_full_nxt;
      s_ready   <= !pend_full_nxt;
      if (xfer)                pend <= s_data;
      if (commit && pend_full) disp <= pend;
    end
  end
endmodule

// File: rtl/ss_scan_driver.sv
// Time-multiplexed common-anode driver: dwell/blank scan FSM over a
// double-buffered frame, with registered, polarity-mapped outputs.
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int N_DIGITS       = 2,
  parameter int SEG_W          = ss_pkg::SEG_W,
  parameter int DWELL_CYCLES   = 4,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [N_DIGITS-1:0][SEG_W-1:0] s_data,
  output logic [SEG_W-1:0]               seg,
  output logic [N_DIGITS-1:0]            an,
  output logic                           frame_start
);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                        ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW = $clog2(CMAX);
  localparam int IW = $clog2((N_DIGITS > 2) ? N_DIGITS : 2);
  localparam logic [SEG_W-1:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  scan_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic advance, commit, last_idx;
  logic [N_DIGITS-1:0][SEG_W-1:0] disp;
  logic [SEG_W-1:0]    seg_lit;
  logic [N_DIGITS-1:0] an_sel;

  ss_frame_buf #(.N_DIGITS(N_DIGITS), .SEG_W(SEG_W)) u_buf (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .commit (commit),
    .disp   (disp)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    advance   = 1'b0;
    last_idx  = (idx == IW'(N_DIGITS - 1));
    case (state)
      SHOW: if (cnt == CW'(DWELL_CYCLES - 1)) begin
        cnt_nxt = '0;
        if (BLANK_CYCLES > 0) state_nxt = BLANK;
        else                  advance   = 1'b1;
      end
      BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) begin
        cnt_nxt   = '0;
        state_nxt = SHOW;
        advance   = 1'b1;
      end
      default: state_nxt = SHOW;
    endcase
    if (advance) idx_nxt = last_idx ? '0 : idx + IW'(1);
    // Wrapping the digit index is the frame boundary.
    commit = advance && last_idx;
  end

  always_comb begin
    seg_lit = SEG_BLANK;
    an_sel  = '0;
    if (state == SHOW) begin
      seg_lit     = disp[idx];
      an_sel[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= SHOW;
      cnt         <= '0;
      idx         <= '0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      seg         <= seg_lit ^ SEG_OFF;
      an          <= an_sel ^ AN_OFF;
      frame_start <= (state == SHOW) && (idx == '0) && (cnt == '0);
    end
  end
endmodule

// File: tb/tb_ss_scan_driver.sv
// Scoreboard bench: a 2-digit default driver and a 4-digit no-gap driver
// checked every cycle against a frame-position model.
module tb_ss_scan_driver;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic v1, r1, fs1;
  logic [1:0][6:0] d1;
  logic [6:0] seg1;
  logic [1:0] an1;
  logic v2, r2, fs2;
  logic [3:0][6:0] d2;
  logic [6:0] seg2;
  logic [3:0] an2;

  ss_scan_driver u_dut (
    .clk(clk), .rstn(rstn), .s_valid(v1), .s_ready(r1), .s_data(d1),
    .seg(seg1), .an(an1), .frame_start(fs1));

  ss_scan_driver #(.N_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut4 (
    .clk(clk), .rstn(rstn), .s_valid(v2), .s_ready(r2), .s_data(d2),
    .seg(seg2), .an(an2), .frame_start(fs2));

  typedef struct {logic [6:0] seg; logic [3:0] an; logic fs; logic rdy;} exp_t;
  typedef struct {int pos; logic pf; logic rdy; logic [3:0][6:0] pend; logic [3:0][6:0] disp;} mdl_t;

  exp_t q1[$], q2[$];
  mdl_t m1, m2;
  logic [1:0][6:0] f1[$];
  logic [3:0][6:0] f2[$];
  int n_vec = 0, n_err = 0;
  logic ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // Frame position within an nd*(dw+bl) cycle frame; outputs follow the
  // position held before each edge.
  task automatic model(input int nd, input int dw, input int bl, input logic rst_n,
                       input logic vld, input logic [3:0][6:0] data,
                       inout mdl_t m, output exp_t e, output logic xfer);
    int per, dig, w;
    logic bnd;
    per = dw + bl;
    xfer = 1'b0;
    e.seg = 7'h7F; e.an = 4'hF; e.fs = 1'b0; e.rdy = 1'b0;
    if (!rst_n) begin
      m.pos = 0; m.pf = 1'b0; m.rdy = 1'b0; m.pend = '0; m.disp = '0;
    end else begin
      dig = m.pos / per;
      w   = m.pos % per;
      if (w < dw) begin
        e.an[dig] = 1'b0;
        e.seg     = ~m.disp[dig];
      end
      e.fs = (m.pos == 0);
      xfer = vld && m.rdy;
      bnd  = (m.pos == nd * per - 1);
      if (bnd && m.pf) begin m.disp = m.pend; m.pf = 1'b0; end
      if (xfer) begin m.pend = data; m.pf = 1'b1; end
      m.rdy = !m.pf;
      e.rdy = m.rdy;
      m.pos = bnd ? 0 : m.pos + 1;
    end
  endtask

  task automatic tick();
    exp_t e;
    logic x;
    logic [3:0][6:0] d;
    v1 = (f1.size() > 0);
    d1 = v1 ? f1[0] : '0;
    v2 = (f2.size() > 0);
    d2 = v2 ? f2[0] : '0;
    d = '0;
    d[1:0] = d1;
    model(2, 4, 1, rstn, v1, d, m1, e, x);
    q1.push_back(e);
    if (x) f1.delete(0);
    model(4, 4, 0, rstn, v2, d2, m2, e, x);
    q2.push_back(e);
    if (x) f2.delete(0);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    chk("seg", seg1, e.seg);
    chk("an", an1, e.an[1:0]);
    chk("frame_start", fs1, e.fs);
    chk("s_ready", r1, e.rdy);
    e = q2.pop_front();
    chk("seg4", seg2, e.seg);
    chk("an4", an2, e.an);
    chk("frame_start4", fs2, e.fs);
    chk("s_ready4", r2, e.rdy);
  endtask

  initial begin
    v1 = 1'b0; d1 = '0; v2 = 1'b0; d2 = '0;
    repeat (2) tick();
    rstn = 1'b1;
    f2.push_back({7'h4F, 7'h5B, 7'h06, 7'h3F});

    f1.push_back({7'h06, 7'h3F});
    repeat (25) tick();

    // Back-to-back frames: second one stalls until the first commits.
    f1.push_back({7'h5B, 7'h4F});
    f1.push_back({7'h66, 7'h6D});
    repeat (35) tick();

    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++)
      if (m1.pos == 9 && m1.rdy) ok = 1'b1; else tick();
    chk("wait_wrap", ok, 1);
    f1.push_back({7'h7D, 7'h07});
    repeat (25) tick();

    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++)
      if (m1.pos == 0 && m1.rdy) ok = 1'b1; else tick();
    chk("wait_frame", ok, 1);
    f1.push_back({7'h7F, 7'h71});
    tick();
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++)
      if (m1.pos == 6) ok = 1'b1; else tick();
    chk("wait_dig1", ok, 1);
    chk("pend_held", r1, 0);
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
